// File: rtl/mem_port_pkg.sv
// Shared encodings and parameter limits for the unified memory port controller.
package mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;

  function automatic bit lat_ok(input int unsigned lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// Arbiter/sequencer for the single memory port: data has fixed priority over fetch,
// address/data are held for MEM_LAT cycles, then the owner is acknowledged.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_load,
  output logic              rdr_load,
  output logic              busy
);

  if (!lat_ok(MEM_LAT)) begin : g_lat_check
    $error("mem_port_ctrl: MEM_LAT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t            r_state, w_state_n;
  owner_t            r_owner, w_owner_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic              r_we, w_we_n;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_n;
  logic [DATA_W-1:0] r_mem_wdata, w_wdata_n;
  logic              r_mem_we, w_mem_we_n;
  logic              w_done;

  // Read data is captured by the external register; only its enable is driven here.
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_FETCH;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_owner     <= w_owner_n;
      r_cnt       <= w_cnt_n;
      r_we        <= w_we_n;
      r_mem_addr  <= w_addr_n;
      r_mem_wdata <= w_wdata_n;
      r_mem_we    <= w_mem_we_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_cnt_n   = r_cnt;
    w_we_n    = r_we;
    w_addr_n  = r_mem_addr;
    w_wdata_n = r_mem_wdata;
    case (r_state)
      ST_ACCESS: begin
        if (r_cnt == '0) w_state_n = ST_DONE;
        else             w_cnt_n   = r_cnt - 1'b1;
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: begin
        // Covers ST_IDLE and the unused 2'b11 code.
        w_state_n = ST_IDLE;
        if (d_req) begin
          w_state_n = ST_ACCESS;
          w_owner_n = OWN_DATA;
          w_cnt_n   = CNT_INIT;
          w_we_n    = d_we;
          w_addr_n  = d_addr;
          w_wdata_n = d_wdata;
        end else if (if_req) begin
          w_state_n = ST_ACCESS;
          w_owner_n = OWN_FETCH;
          w_cnt_n   = CNT_INIT;
          w_we_n    = 1'b0;
          w_addr_n  = if_addr;
        end
      end
    endcase
    // Registered strobe: look ahead so it lands on the last ACCESS cycle.
    w_mem_we_n = (w_state_n == ST_ACCESS) && (w_cnt_n == '0) && w_we_n;
  end

  always_comb begin
    busy     = (r_state == ST_ACCESS) || (r_state == ST_DONE);
    w_done   = (r_state == ST_DONE) && !rst;
    if_ack   = w_done && (r_owner == OWN_FETCH);
    d_ack    = w_done && (r_owner == OWN_DATA);
    ir_load  = if_ack;
    rdr_load = d_ack && !r_we;
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed vectors, corner sequences, random traffic vs timeline model.
module tb_mem_port_ctrl;

  localparam int unsigned L  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_ack, d_ack, mem_we, ir_load, rdr_load, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.MEM_LAT(L), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ir_load(ir_load), .rdr_load(rdr_load), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        dreq, dwe, ireq;
    logic [31:0] addr, wdata, rdata;
    logic        e_we, e_iack, e_dack, e_ir, e_rdr;
  } vec_t;

  vec_t vecs[5];

  // random-phase model: position in the grant timeline (0 = idle, 1..L access, L+1 done)
  int unsigned mk;
  logic        m_data, m_we, drop_i, drop_d, e_iack, e_dack;
  logic [31:0] m_addr, m_wdata;
  int          rdr_cnt;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {if_ack, d_ack, ir_load, rdr_load}, 0);
    rst = 1'b0;

    // directed single transactions
    for (int i = 0; i < 5; i++) begin
      d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      if_req = vecs[i].ireq; if_addr = vecs[i].addr; mem_rdata = vecs[i].rdata;
      chk("vec_idle_busy", busy, 0);
      for (int c = 1; c <= int'(L); c++) begin
        tick();
        chk("vec_acc_busy", busy, 1);
        chk("vec_acc_addr", mem_addr, vecs[i].addr);
        chk("vec_acc_we", mem_we, (c == int'(L)) ? vecs[i].e_we : 1'b0);
        if (vecs[i].e_we) chk("vec_acc_wdata", mem_wdata, vecs[i].wdata);
        chk("vec_acc_acks", {if_ack, d_ack, ir_load, rdr_load}, 0);
      end
      tick();
      chk("vec_done_outs", {if_ack, d_ack, ir_load, rdr_load},
          {vecs[i].e_iack, vecs[i].e_dack, vecs[i].e_ir, vecs[i].e_rdr});
      chk("vec_done_we", mem_we, 0);
      chk("vec_done_busy", busy, 1);
      tick();
      d_req = 1'b0; if_req = 1'b0;
      chk("vec_after_busy", busy, 0);
      chk("vec_after_acks", {if_ack, d_ack, ir_load, rdr_load}, 0);
    end

    // simultaneous requests: data first, then fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h44;
    tick(); tick();
    chk("pri_c2_addr", mem_addr, 32'h300);
    tick();
    chk("pri_c3_acks", {if_ack, d_ack, ir_load, rdr_load}, 4'b0101);
    tick();
    d_req = 1'b0;
    chk("pri_c4_busy", busy, 0);
    tick();
    chk("pri_c5_addr", mem_addr, 32'h44);
    chk("pri_c5_we", mem_we, 0);
    tick(); tick();
    chk("pri_c7_acks", {if_ack, d_ack, ir_load, rdr_load}, 4'b1010);
    chk("pri_c7_addr", mem_addr, 32'h44);
    tick();
    if_req = 1'b0;
    chk("pri_c8_busy", busy, 0);

    // reset in the middle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
    tick();
    chk("rmid_c1_busy", busy, 1);
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rmid_c2_busy", busy, 0);
    chk("rmid_c2_we", mem_we, 0);
    chk("rmid_c2_addr", mem_addr, 0);
    chk("rmid_c2_wdata", mem_wdata, 0);
    chk("rmid_c2_acks", {if_ack, d_ack, ir_load, rdr_load}, 0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("rmid_quiet", {mem_we, d_ack, busy}, 0);
    end

    // back-to-back loads
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    rdr_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 4) d_addr = 32'h104;
      if (c == 8) d_req = 1'b0;
      if (rdr_load) rdr_cnt++;
      chk("b2b_dack", d_ack, (c == 3 || c == 7) ? 1'b1 : 1'b0);
      if (c == 5) chk("b2b_addr2", mem_addr, 32'h104);
    end
    chk("b2b_rdr_pulses", rdr_cnt, 2);

    // random traffic against timeline model
    rst = 1'b1; d_req = 1'b0; if_req = 1'b0;
    tick();
    rst = 1'b0;
    mk = 0; m_data = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    drop_i = 1'b0; drop_d = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      e_iack = (mk == L + 1) && !m_data;
      e_dack = (mk == L + 1) && m_data;
      chk("rnd_busy", busy, (mk != 0) ? 1'b1 : 1'b0);
      chk("rnd_we", mem_we, (mk == L && m_we) ? 1'b1 : 1'b0);
      chk("rnd_acks", {if_ack, d_ack, ir_load, rdr_load},
          {e_iack, e_dack, e_iack, e_dack && !m_we});
      if (mk != 0) chk("rnd_addr", mem_addr, m_addr);
      if (mk != 0 && m_we) chk("rnd_wdata", mem_wdata, m_wdata);

      if (drop_i) if_req = 1'b0;
      else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (drop_d) d_req = 1'b0;
      else if (!d_req && $urandom_range(3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      drop_i = e_iack;
      drop_d = e_dack;

      if (mk == 0) begin
        if (d_req) begin
          m_data = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; mk = 1;
        end else if (if_req) begin
          m_data = 1'b0; m_we = 1'b0; m_addr = if_addr; mk = 1;
        end
      end else if (mk <= L) mk++;
      else mk = 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
